// File: rtl/conv_window_fetcher.sv
// Walks a row-major image in block RAM and streams every valid-mode 3x3 window
// in raster order; each window is gathered one tap per cycle, then presented.
//
// state   | meaning
// IDLE    | waiting for i_start
// FETCH   | reading tap k (0..8) of the current window
// PRESENT | window held on the stream until accepted
// DONE    | one-cycle job-end pulse
module conv_window_fetcher #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [DIM_WIDTH-1:0]    i_width,
  input  logic [DIM_WIDTH-1:0]    i_height,
  output logic                    o_re,
  output logic [ADDR_WIDTH-1:0]   o_read_addr,
  input  logic [DATA_WIDTH-1:0]   i_rd_data,
  output logic [9*DATA_WIDTH-1:0] o_window,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]              state_q;
  logic [DIM_WIDTH-1:0]    w_q;
  logic [DIM_WIDTH-1:0]    h_q;
  logic [DIM_WIDTH-1:0]    x_q;
  logic [DIM_WIDTH-1:0]    y_q;
  logic [3:0]              k_q;
  logic [ADDR_WIDTH-1:0]   origin_q;
  logic [9*DATA_WIDTH-1:0] window_q;

  logic [ADDR_WIDTH-1:0]   w_ext;
  logic [ADDR_WIDTH-1:0]   row_off;
  logic [ADDR_WIDTH-1:0]   col_off;
  logic [ADDR_WIDTH-1:0]   fetch_addr;
  logic                    x_end;
  logic                    y_end;
  logic                    bad_dims;

  // origin_q tracks base + y*W + x incrementally, so no multiplier is needed
  assign w_ext = ADDR_WIDTH'(w_q);

  always_comb begin
    row_off = '0;
    col_off = '0;
    case (k_q)
      4'd0: begin row_off = '0;          col_off = ADDR_WIDTH'(0); end
      4'd1: begin row_off = '0;          col_off = ADDR_WIDTH'(1); end
      4'd2: begin row_off = '0;          col_off = ADDR_WIDTH'(2); end
      4'd3: begin row_off = w_ext;       col_off = ADDR_WIDTH'(0); end
      4'd4: begin row_off = w_ext;       col_off = ADDR_WIDTH'(1); end
      4'd5: begin row_off = w_ext;       col_off = ADDR_WIDTH'(2); end
      4'd6: begin row_off = w_ext << 1;  col_off = ADDR_WIDTH'(0); end
      4'd7: begin row_off = w_ext << 1;  col_off = ADDR_WIDTH'(1); end
      4'd8: begin row_off = w_ext << 1;  col_off = ADDR_WIDTH'(2); end
      default: begin row_off = '0;       col_off = '0; end
    endcase
  end

  assign fetch_addr = origin_q + row_off + col_off;
  assign x_end      = (x_q == w_q - DIM_WIDTH'(3));
  assign y_end      = (y_q == h_q - DIM_WIDTH'(3));
  assign bad_dims   = (i_width < DIM_WIDTH'(3)) || (i_height < DIM_WIDTH'(3));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      origin_q <= '0;
      window_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            w_q      <= i_width;
            h_q      <= i_height;
            x_q      <= '0;
            y_q      <= '0;
            k_q      <= '0;
            origin_q <= i_base_addr;
            state_q  <= bad_dims ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          for (int i = 0; i < 9; i++) begin
            if (k_q == 4'(i)) window_q[i*DATA_WIDTH +: DATA_WIDTH] <= i_rd_data;
          end
          if (k_q == 4'd8) begin
            k_q     <= '0;
            state_q <= S_PRESENT;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        S_PRESENT: begin
          if (i_ready) begin
            if (x_end && y_end) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
              if (x_end) begin
                // from column W-3 of row y to column 0 of row y+1 is +3
                x_q      <= '0;
                y_q      <= y_q + DIM_WIDTH'(1);
                origin_q <= origin_q + ADDR_WIDTH'(3);
              end else begin
                x_q      <= x_q + DIM_WIDTH'(1);
                origin_q <= origin_q + ADDR_WIDTH'(1);
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_re        = (state_q == S_FETCH);
  assign o_read_addr = (state_q == S_FETCH) ? fetch_addr : '0;
  assign o_window    = window_q;
  assign o_valid     = (state_q == S_PRESENT);
  assign o_last      = (state_q == S_PRESENT) && x_end && y_end;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_fetcher.sv
// Directed bench for conv_window_fetcher; RAM model returns RAM[i]=i combinationally.
module tb_conv_window_fetcher;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [13:0]  i_base_addr;
  logic [7:0]   i_width;
  logic [7:0]   i_height;
  logic         o_re;
  logic [13:0]  o_read_addr;
  logic [31:0]  i_rd_data;
  logic [287:0] o_window;
  logic         o_valid;
  logic         i_ready;
  logic         o_last;
  logic         o_busy;
  logic         o_done;

  int tests = 0;
  int fails = 0;

  int first_taps[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int min_taps[9]   = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
  int wrap_taps[9]  = '{16382, 16383, 0, 1, 2, 3, 4, 5, 6};

  conv_window_fetcher dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_width     (i_width),
    .i_height    (i_height),
    .o_re        (o_re),
    .o_read_addr (o_read_addr),
    .i_rd_data   (i_rd_data),
    .o_window    (o_window),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  assign i_rd_data = 32'(o_read_addr);

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [287:0] pack9(input int t[9]);
    logic [287:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*32 +: 32] = 32'(t[k]);
    return r;
  endfunction

  function automatic int tap_addr(input int base, input int w, input int x, input int y, input int k);
    return (base + (y + k / 3) * w + x + k % 3) % 16384;
  endfunction

  function automatic logic [287:0] exp_win(input int base, input int w, input int x, input int y);
    int t[9];
    for (int k = 0; k < 9; k++) t[k] = tap_addr(base, w, x, y, k);
    return pack9(t);
  endfunction

  task automatic start_job(input int base, input int w, input int h);
    i_base_addr = 14'(base);
    i_width     = 8'(w);
    i_height    = 8'(h);
    i_start     = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  // Called #1 after the start edge; returns #1 after the edge that ends the last tap.
  task automatic fetch_window(input string tag, input int base, input int w, input int x, input int y);
    for (int j = 0; j < 9; j++) begin
      check({tag, "_re"}, 288'(o_re), 288'(1));
      check({tag, "_valid_low"}, 288'(o_valid), 288'(0));
      check({tag, "_addr"}, 288'(o_read_addr), 288'(tap_addr(base, w, x, y, j)));
      tick();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_re"},    288'(o_re), 288'(0));
    check({tag, "_addr"},  288'(o_read_addr), 288'(0));
    check({tag, "_valid"}, 288'(o_valid), 288'(0));
    check({tag, "_last"},  288'(o_last), 288'(0));
    check({tag, "_busy"},  288'(o_busy), 288'(0));
    check({tag, "_done"},  288'(o_done), 288'(0));
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_width     = '0;
    i_height    = '0;
    i_ready     = 1'b0;
    #2;
    check_idle_outputs("reset");
    check("reset_window", o_window, '0);
    #20;
    i_rst_n = 1'b1;
    tick();

    // minimum 3x3 image
    i_ready = 1'b1;
    start_job(0, 3, 3);
    fetch_window("min", 0, 3, 0, 0);
    check("min_valid", 288'(o_valid), 288'(1));
    check("min_last", 288'(o_last), 288'(1));
    check("min_window", o_window, pack9(min_taps));
    check("min_re_present", 288'(o_re), 288'(0));
    tick();
    check("min_done", 288'(o_done), 288'(1));
    check("min_done_busy", 288'(o_busy), 288'(1));
    check("min_done_valid", 288'(o_valid), 288'(0));
    tick();
    check("min_idle_done", 288'(o_done), 288'(0));
    check("min_idle_busy", 288'(o_busy), 288'(0));

    // 5x4 image: six windows in raster order
    start_job(0, 5, 4);
    for (int n = 0; n < 6; n++) begin
      fetch_window("w5h4", 0, 5, n % 3, n / 3);
      check("w5h4_valid", 288'(o_valid), 288'(1));
      check("w5h4_window", o_window, exp_win(0, 5, n % 3, n / 3));
      check("w5h4_last", 288'(o_last), 288'(n == 5));
      if (n == 0) check("w5h4_first", o_window, pack9(first_taps));
      if (n == 3) check("w5h4_fourth_tap0", 288'(o_window[31:0]), 288'(5));
      if (n == 5) begin
        check("w5h4_last_tap0", 288'(o_window[31:0]), 288'(7));
        check("w5h4_last_tap8", 288'(o_window[287:256]), 288'(19));
      end
      tick();
    end
    check("w5h4_done", 288'(o_done), 288'(1));
    tick();
    check("w5h4_idle", 288'(o_busy), 288'(0));

    // backpressure
    i_ready = 1'b0;
    start_job(0, 3, 3);
    fetch_window("bp", 0, 3, 0, 0);
    for (int j = 0; j < 5; j++) begin
      check("bp_valid", 288'(o_valid), 288'(1));
      check("bp_window", o_window, pack9(min_taps));
      check("bp_last", 288'(o_last), 288'(1));
      check("bp_re", 288'(o_re), 288'(0));
      tick();
    end
    check("bp_still_valid", 288'(o_valid), 288'(1));
    i_ready = 1'b1;
    tick();
    check("bp_done", 288'(o_done), 288'(1));
    check("bp_valid_drop", 288'(o_valid), 288'(0));
    tick();

    // invalid dimensions
    start_job(0, 2, 10);
    check("bad_w_done", 288'(o_done), 288'(1));
    check("bad_w_busy", 288'(o_busy), 288'(1));
    check("bad_w_re", 288'(o_re), 288'(0));
    check("bad_w_valid", 288'(o_valid), 288'(0));
    tick();
    check("bad_w_idle", 288'(o_busy), 288'(0));
    check("bad_w_done_end", 288'(o_done), 288'(0));
    start_job(0, 10, 0);
    check("bad_h_done", 288'(o_done), 288'(1));
    check("bad_h_busy", 288'(o_busy), 288'(1));
    check("bad_h_re", 288'(o_re), 288'(0));
    check("bad_h_valid", 288'(o_valid), 288'(0));
    tick();
    check("bad_h_idle", 288'(o_busy), 288'(0));

    // busy start ignored, then reset at tap 4 of a 4x4 job
    start_job(0, 4, 4);
    for (int j = 0; j < 4; j++) begin
      check("rst_job_addr", 288'(o_read_addr), 288'(tap_addr(0, 4, 0, 0, j)));
      if (j == 1) begin
        i_start     = 1'b1;
        i_base_addr = 14'd100;
        i_width     = 8'd3;
      end
      tick();
      i_start = 1'b0;
    end
    check("rst_tap4_re", 288'(o_re), 288'(1));
    check("rst_tap4_addr", 288'(o_read_addr), 288'(5));
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid_window", o_window, '0);
    #1;
    i_rst_n = 1'b1;
    start_job(0, 3, 3);
    fetch_window("restart", 0, 3, 0, 0);
    check("restart_valid", 288'(o_valid), 288'(1));
    check("restart_window", o_window, pack9(min_taps));
    tick();
    check("restart_done", 288'(o_done), 288'(1));
    tick();

    // address wrap past the top of RAM
    start_job(16382, 3, 3);
    for (int j = 0; j < 9; j++) begin
      check("wrap_addr", 288'(o_read_addr), 288'(wrap_taps[j]));
      check("wrap_re", 288'(o_re), 288'(1));
      tick();
    end
    check("wrap_valid", 288'(o_valid), 288'(1));
    check("wrap_window", o_window, pack9(wrap_taps));
    tick();
    check("wrap_done", 288'(o_done), 288'(1));
    tick();
    check("wrap_idle", 288'(o_busy), 288'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
